fpu_issuer: RTL and testbench

Command-side initiator for the multi-cycle floating-point unit. It accepts operation commands (two operands, op code, destination tag) into a small FIFO and drives the FPU's start/done handshake one operation at a time. It returns each result, with its tag, over a valid/ready result port. It sits between the decode/register-read stage and `fpu`, and owns all operand stability and sequencing on the FPU interface.

---
 rtl/fpu_pkg.sv | 31 +++
 rtl/fpu_issuer_fifo.sv | 62 ++++++
 rtl/fpu_issuer.sv | 173 +++++++++++++++++
 tb/tb_fpu_issuer.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// Shared definitions for the FPU command issuer: datapath widths, the
// canonical quiet NaN, the default watchdog limit, the issuer FSM encoding
// and the packed command record stored in the command FIFO.
package fpu_pkg;

  localparam int FP_W  = 32;
  localparam int OP_W  = 2;
  localparam int TAG_W = 5;

  // Width of one queued command {a, b, op, tag}.
  localparam int CMD_W = 2 * FP_W + OP_W + TAG_W;

  localparam logic [FP_W-1:0] FP_QNAN = 32'h7FC0_0000;

  localparam int DEFAULT_TIMEOUT_CYCLES = 64;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_WB    = 2'd3
  } state_e;

  typedef struct packed {
    logic [FP_W-1:0]  a;
    logic [FP_W-1:0]  b;
    logic [OP_W-1:0]  op;
    logic [TAG_W-1:0] tag;
  } cmd_t;

endpackage

// File: rtl/fpu_issuer_fifo.sv
// Synchronous command FIFO for the FPU issuer. Pointers carry one extra wrap
// bit so full and empty are told apart without a separate occupancy counter.
// Pushes into a full FIFO and pops from an empty one are ignored.
module fpu_issuer_fifo
  import fpu_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int WIDTH = CMD_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem_q[rd_ptr_q[AW-1:0]];

  // Advance the pointers on accepted push/pop.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and no latch is inferred.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  // Pointer registers; reset flushes the FIFO.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage write.
  // NOTE: the storage array has no reset; contents are only visible once the pointers mark them valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/fpu_issuer.sv
// Command-side initiator for the multi-cycle FPU. Queues commands, issues
// them one at a time over the start/done handshake and returns each tagged
// result on a valid/ready port, in command order.
// Optional feature: define FPU_ISSUER_TIMEOUT_EN to add a WAIT-state
// watchdog that returns a qNaN with res_err=1 after TIMEOUT_CYCLES.
module fpu_issuer
  import fpu_pkg::*;
#(
  parameter int DEPTH = 2
`ifdef FPU_ISSUER_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
`endif
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_a,
  input  logic [31:0] cmd_b,
  input  logic [1:0]  cmd_op,
  input  logic [4:0]  cmd_tag,
  output logic [31:0] fpu_a,
  output logic [31:0] fpu_b,
  output logic [1:0]  fpu_op,
  output logic        fpu_start,
  input  logic        fpu_done,
  input  logic [31:0] fpu_r,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_data,
  output logic [4:0]  res_tag,
  output logic        res_err,
  output logic        busy
);

  state_e            state_q, state_d;
  logic [FP_W-1:0]   fpu_a_q, fpu_a_d;
  logic [FP_W-1:0]   fpu_b_q, fpu_b_d;
  logic [OP_W-1:0]   fpu_op_q, fpu_op_d;
  logic [TAG_W-1:0]  tag_q, tag_d;
  logic [FP_W-1:0]   res_data_q, res_data_d;
  logic              fifo_full, fifo_empty;
  logic              push, pop;
  cmd_t              cmd_in, head;

`ifdef FPU_ISSUER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             res_err_q, res_err_d;
`endif

  assign cmd_ready = !fifo_full && !rst;
  assign push      = cmd_valid && cmd_ready;
  assign cmd_in    = '{a: cmd_a, b: cmd_b, op: cmd_op, tag: cmd_tag};

  fpu_issuer_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (CMD_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (cmd_in),
    .pop   (pop),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign fpu_a     = fpu_a_q;
  assign fpu_b     = fpu_b_q;
  assign fpu_op    = fpu_op_q;
  assign fpu_start = (state_q == ST_ISSUE);
  assign res_valid = (state_q == ST_WB);
  assign res_data  = res_data_q;
  assign res_tag   = tag_q;
  assign busy      = (state_q != ST_IDLE) || !fifo_empty;
`ifdef FPU_ISSUER_TIMEOUT_EN
  assign res_err   = res_err_q;
`else
  assign res_err   = 1'b0;
`endif

  // Next-state, FIFO pop and operand/result capture for the issue sequence.
  always_comb begin
    logic load;
    load       = 1'b0;
    state_d    = state_q;
    fpu_a_d    = fpu_a_q;
    fpu_b_d    = fpu_b_q;
    fpu_op_d   = fpu_op_q;
    tag_d      = tag_q;
    res_data_d = res_data_q;
    pop        = 1'b0;
`ifdef FPU_ISSUER_TIMEOUT_EN
    cnt_d      = cnt_q;
    res_err_d  = res_err_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) load = 1'b1;
      end
      ST_ISSUE: begin
        // fpu_done is ignored here; the FPU cannot finish before next cycle.
        state_d = ST_WAIT;
`ifdef FPU_ISSUER_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      ST_WAIT: begin
        if (fpu_done) begin
          res_data_d = fpu_r;
          state_d    = ST_WB;
`ifdef FPU_ISSUER_TIMEOUT_EN
          res_err_d  = 1'b0;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          // Limit reached without done: report a canonical qNaN, keep the tag.
          res_data_d = FP_QNAN;
          res_err_d  = 1'b1;
          state_d    = ST_WB;
        end else begin
          cnt_d = cnt_q + 1'b1;
`endif
        end
      end
      ST_WB: begin
        if (res_ready) begin
          if (!fifo_empty) load = 1'b1;
          else             state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Shared by IDLE and the back-to-back path out of WB.
    if (load) begin
      pop      = 1'b1;
      fpu_a_d  = head.a;
      fpu_b_d  = head.b;
      fpu_op_d = head.op;
      tag_d    = head.tag;
      state_d  = ST_ISSUE;
    end
  end

  // State, operand and result registers; reset clears every output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      fpu_a_q    <= '0;
      fpu_b_q    <= '0;
      fpu_op_q   <= '0;
      tag_q      <= '0;
      res_data_q <= '0;
`ifdef FPU_ISSUER_TIMEOUT_EN
      cnt_q      <= '0;
      res_err_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      fpu_a_q    <= fpu_a_d;
      fpu_b_q    <= fpu_b_d;
      fpu_op_q   <= fpu_op_d;
      tag_q      <= tag_d;
      res_data_q <= res_data_d;
`ifdef FPU_ISSUER_TIMEOUT_EN
      cnt_q      <= cnt_d;
      res_err_q  <= res_err_d;
`endif
    end
  end

endmodule

// File: tb/tb_fpu_issuer.sv
// Self-checking bench for fpu_issuer: behavioural FPU (done 5 cycles after
// start), scoreboard of expected results filled as commands are accepted
// and drained as results are handshaken.
module tb_fpu_issuer;
  import fpu_pkg::*;

  localparam int TB_TIMEOUT = 8;

  typedef struct packed {
    logic [31:0] data;
    logic [4:0]  tag;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready;
  logic [31:0] cmd_a, cmd_b;
  logic [1:0]  cmd_op;
  logic [4:0]  cmd_tag;
  logic [31:0] fpu_a, fpu_b;
  logic [1:0]  fpu_op;
  logic        fpu_start, fpu_done;
  logic [31:0] fpu_r;
  logic        res_valid, res_ready;
  logic [31:0] res_data;
  logic [4:0]  res_tag;
  logic        res_err, busy;

  int   checks   = 0;
  int   failures = 0;
  exp_t sb[$];

  logic        m_never = 1'b0;
  int unsigned m_cnt;

  always #5 clk = ~clk;

  fpu_issuer #(
    .DEPTH (2)
`ifdef FPU_ISSUER_TIMEOUT_EN
    , .TIMEOUT_CYCLES (TB_TIMEOUT)
`endif
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_a     (cmd_a),
    .cmd_b     (cmd_b),
    .cmd_op    (cmd_op),
    .cmd_tag   (cmd_tag),
    .fpu_a     (fpu_a),
    .fpu_b     (fpu_b),
    .fpu_op    (fpu_op),
    .fpu_start (fpu_start),
    .fpu_done  (fpu_done),
    .fpu_r     (fpu_r),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_tag   (res_tag),
    .res_err   (res_err),
    .busy      (busy)
  );

  // Result function of the FPU stand-in: exact for 1.0 + 2.0, otherwise a
  // value that depends on every operand and op bit.
  function automatic logic [31:0] fpu_model(input logic [31:0] a, input logic [31:0] b,
                                            input logic [1:0] op);
    if (a == 32'h3F80_0000 && b == 32'h4000_0000 && op == 2'b00) return 32'h4040_0000;
    return (a ^ {b[15:0], b[31:16]}) + {30'd0, op};
  endfunction

  // Behavioural FPU: done one cycle, 5 cycles after start; the result is
  // computed from the operands present at done time.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cnt    <= 0;
      fpu_done <= 1'b0;
      fpu_r    <= '0;
    end else begin
      fpu_done <= 1'b0;
      if (fpu_start) begin
        m_cnt <= 4;
      end else if (m_cnt != 0) begin
        m_cnt <= m_cnt - 1;
        if (m_cnt == 1 && !m_never) begin
          fpu_done <= 1'b1;
          fpu_r    <= fpu_model(fpu_a, fpu_b, fpu_op);
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op,
                      input logic [4:0] tag, input logic exp_err);
    int n = 0;
    cmd_a = a; cmd_b = b; cmd_op = op; cmd_tag = tag;
    cmd_valid = 1'b1;
    while (!cmd_ready && n < 50) begin
      tick();
      n++;
    end
    check("cmd_accept", {31'd0, cmd_ready}, 32'd1);
    if (cmd_ready) sb.push_back('{exp_err ? FP_QNAN : fpu_model(a, b, op), tag, exp_err});
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_valid(input string tag, input int limit);
    int n = 0;
    while (!res_valid && n < limit) begin
      tick();
      n++;
    end
    check(tag, {31'd0, res_valid}, 32'd1);
  endtask

  task automatic take_result(input string tag, input int limit, input logic expect_start);
    exp_t e;
    wait_valid({tag, "_valid"}, limit);
    check({tag, "_sb_nonempty"}, {31'd0, sb.size() > 0}, 32'd1);
    e = (sb.size() > 0) ? sb.pop_front() : '0;
    check({tag, "_data"}, res_data, e.data);
    check({tag, "_tag"}, {27'd0, res_tag}, {27'd0, e.tag});
    check({tag, "_err"}, {31'd0, res_err}, {31'd0, e.err});
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check({tag, "_next_start"}, {31'd0, fpu_start}, {31'd0, expect_start});
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_fpu_a"}, fpu_a, 32'd0);
    check({tag, "_fpu_b"}, fpu_b, 32'd0);
    check({tag, "_fpu_op"}, {30'd0, fpu_op}, 32'd0);
    check({tag, "_fpu_start"}, {31'd0, fpu_start}, 32'd0);
    check({tag, "_res_valid"}, {31'd0, res_valid}, 32'd0);
    check({tag, "_res_data"}, res_data, 32'd0);
    check({tag, "_res_tag"}, {27'd0, res_tag}, 32'd0);
    check({tag, "_res_err"}, {31'd0, res_err}, 32'd0);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_cmd_ready"}, {31'd0, cmd_ready}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    int   n;
    logic seen;

    rst = 1'b1; cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; cmd_op = '0; cmd_tag = '0;
    res_ready = 1'b0;
    #1;
    tick();
    check_all_zero("reset");
    tick();
    rst = 1'b0;
    tick();
    check("idle_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    check("idle_busy", {31'd0, busy}, 32'd0);

    // Single op: accepted at N, start at N+2, result 6 cycles after start.
    send(32'h3F80_0000, 32'h4000_0000, 2'b00, 5'd3, 1'b0);
    check("single_no_start_n1", {31'd0, fpu_start}, 32'd0);
    check("single_busy", {31'd0, busy}, 32'd1);
    tick();
    check("single_start_n2", {31'd0, fpu_start}, 32'd1);
    check("single_fpu_a", fpu_a, 32'h3F80_0000);
    check("single_fpu_b", fpu_b, 32'h4000_0000);
    check("single_fpu_op", {30'd0, fpu_op}, 32'd0);
    tick();
    check("single_start_one_cycle", {31'd0, fpu_start}, 32'd0);
    n = 1;
    while (!res_valid && n < 20) begin
      tick();
      n++;
    end
    check("single_latency", n, 32'd6);
    take_result("single", 5, 1'b0);
    check("single_idle_busy", {31'd0, busy}, 32'd0);

    // Fill: three commands with res_ready low; DEPTH=2 fills up.
    send(32'h1111_0001, 32'h2222_0001, 2'b01, 5'd1, 1'b0);
    send(32'h1111_0002, 32'h2222_0002, 2'b10, 5'd2, 1'b0);
    send(32'h1111_0003, 32'h2222_0003, 2'b11, 5'd3, 1'b0);
    check("fill_cmd_ready_full", {31'd0, cmd_ready}, 32'd0);
    check("fill_busy", {31'd0, busy}, 32'd1);
    take_result("fill1", 40, 1'b1);
    check("fill_cmd_ready_freed", {31'd0, cmd_ready}, 32'd1);
    take_result("fill2", 40, 1'b1);
    take_result("fill3", 40, 1'b0);

    // Backpressure: result held 10 cycles, no new start though a command waits.
    send(32'hC0A0_0000, 32'h3F00_0000, 2'b10, 5'd17, 1'b0);
    wait_valid("bp_valid", 40);
    e = sb[0];
    send(32'h4120_0000, 32'hBF80_0000, 2'b01, 5'd30, 1'b0);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("bp_valid_hold", {31'd0, res_valid}, 32'd1);
      check("bp_data_hold", res_data, e.data);
      check("bp_tag_hold", {27'd0, res_tag}, {27'd0, e.tag});
      check("bp_no_start", {31'd0, fpu_start}, 32'd0);
    end
    take_result("bp1", 5, 1'b1);
    take_result("bp2", 40, 1'b0);

    // Reset mid-WAIT at start+2 with a second command queued.
    send(32'h0000_00AA, 32'h0000_00BB, 2'b01, 5'd5, 1'b0);
    send(32'h0000_00CC, 32'h0000_00DD, 2'b10, 5'd6, 1'b0);
    check("rst_start", {31'd0, fpu_start}, 32'd1);
    tick();
    tick();
    rst = 1'b1;
    #1;
    sb.delete();
    check_all_zero("midwait_rst");
    tick();
    tick();
    rst = 1'b0;
    tick();
    check("post_rst_busy", {31'd0, busy}, 32'd0);
    check("post_rst_res_valid", {31'd0, res_valid}, 32'd0);
    check("post_rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    send(32'h3F80_0000, 32'h4000_0000, 2'b00, 5'd12, 1'b0);
    take_result("post_rst", 40, 1'b0);

    // Timeout behaviour: FPU never signals done.
    m_never = 1'b1;
`ifdef FPU_ISSUER_TIMEOUT_EN
    send(32'h1234_5678, 32'h9ABC_DEF0, 2'b11, 5'd9, 1'b1);
    take_result("timeout", 100, 1'b0);
`else
    send(32'h1234_5678, 32'h9ABC_DEF0, 2'b11, 5'd9, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (res_valid) seen = 1'b1;
    end
    check("no_timeout_stays_wait", {31'd0, seen}, 32'd0);
    check("no_timeout_busy", {31'd0, busy}, 32'd1);
`endif
    rst = 1'b1;
    tick();
    sb.delete();
    m_never = 1'b0;
    rst = 1'b0;
    tick();
    send(32'h4080_0000, 32'h4100_0000, 2'b01, 5'd21, 1'b0);
    take_result("recover", 40, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
